decode_buffered: RTL and testbench
==================================

Name: decode_buffered

Overview:
- Parametrised successor to the single-entry decode stage.
- Fully decodes RV32I instructions: register fields, format-correct sign-extended immediate, 4-bit ALUOp, illegal-opcode flag.
- Decoded results are held in a DEPTH-entry FIFO between fetch and rename/dispatch, so fetch can run ahead while downstream stalls.
- Valid/ready handshake on both sides; synchronous flush for branch mispredict recovery.

Parameters:
XLEN, 32, data/PC/immediate width (only 32 supported; checked by assertion)
DEPTH, 4, number of buffered decoded entries; power of two, >= 2
CNT_W, $clog2(DEPTH+1), width of occupancy count (derived, localparam)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-high reset
flush  input  1  synchronous flush; discards all buffered entries
instr  input  32  raw instruction from fetch
pc_in  input  XLEN  PC of instr
valid_in  input  1  instr/pc_in valid
ready_in  output  1  block can accept an instruction this cycle
ready_out  input  1  downstream can accept head entry
valid_out  output  1  head entry valid
pc_out  output  XLEN  PC of head entry
rs1  output  5  source register 1
rs2  output  5  source register 2
rd  output  5  destination register (0 if format writes none)
imm  output  XLEN  sign-extended immediate
ALUOp  output  4  {alt bit, funct3}
OpCode  output  7  instr[6:0]
illegal  output  1  unsupported opcode or instr[1:0] != 2'b11
count  output  CNT_W  current occupancy

Behaviour:
- Reset (async, active-high): wr_ptr, rd_ptr, count = 0; valid_out = 0; ready_in = 1 once reset deasserts. Storage arrays need not be reset. Every decoded output is forced to 0 whenever valid_out = 0, including during reset.
- Push occurs when valid_in && ready_in && !flush. The decode of instr is combinational and is written with pc_in into entry wr_ptr; wr_ptr wraps modulo DEPTH.
- Pop occurs when valid_out && ready_out && !flush. rd_ptr advances and wraps modulo DEPTH.
- Latency: an instruction accepted at edge N is presented at valid_out after edge N (1 cycle) if the FIFO was empty. There is no combinational path from input to output.
- ready_in = (count != DEPTH) && !flush. It is registered-state based and does not depend on ready_out.
- Full: a simultaneous pop does not enable a push in the same cycle.
- valid_out = (count != 0). Outputs are driven from entry rd_ptr.
- Simultaneous push and pop (not full, not empty): count is unchanged; both pointers advance.
- Flush: at the next edge, pointers and count = 0. Flush has priority over push and pop in the same cycle; valid_out falls the cycle after.
- Immediate generation by opcode:
  - I-type (0010011, 0000011, 1100111, 1110011): sext(instr[31:20])
  - S-type (0100011): sext({[31:25],[11:7]})
  - B-type (1100011): sext({[31],[7],[30:25],[11:8],0})
  - U-type (0110111, 0010111): {[31:12], 12'b0}
  - J-type (1101111): sext({[31],[19:12],[20],[30:21],0})
  - R-type (0110011): 0
- rd = 0 for S and B types; otherwise instr[11:7]. rs1/rs2 are always instr[19:15]/[24:20].
- ALUOp[3] = instr[30] for R-type, and for OP-IMM with funct3 = 101; otherwise 0. ALUOp[2:0] = funct3.
- illegal = 1 for any opcode not listed above, or when instr[1:0] != 2'b11. The entry is still enqueued with imm = 0, for downstream exception handling.
- pc_out, OpCode, and all decode fields of an entry are stable while valid_out && !ready_out.

Test Plan:
- Single push: 0xFFB10093 (addi x1,x2,-5), pc 0x100 -> next cycle valid_out=1, rd=1, rs1=2, imm=0xFFFFFFFB, ALUOp=0000, OpCode=0x13, illegal=0, pc_out=0x100.
- Formats: 0x00532423 (sw x5,8(x6)) -> imm=0x8, rs1=6, rs2=5, rd=0. Then 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, rd=0. Then 0x402081B3 (sub x3,x1,x2) -> ALUOp=1000, imm=0.
- Fill/stall, DEPTH=4: ready_out=0, push 5 consecutive instructions -> count reaches 4, ready_in=0, 5th held upstream. Raise ready_out -> drains in order; 5th accepted once count=3. Assert count==4 with ready_out=1 and valid_in=1 -> only a pop happens, count=3.
- Streaming: valid_in=ready_out=1 continuously -> count stays 1, one instruction per cycle, order and PCs preserved across pointer wrap (>= 2*DEPTH instructions).
- Flush with count=3 and simultaneous valid_in=1 -> next cycle count=0, valid_out=0, flushed-cycle instruction not enqueued.
- Async reset asserted mid-stream between clock edges -> valid_out, count and all outputs go 0 immediately without a clock edge. Illegal instr 0x00000000 after reset -> enqueued with illegal=1, imm=0.

Source files
------------

// File: rtl/decode_buffered_if.sv
// Fetch-side and dispatch-side signals of the buffered decode stage.
// slave is the decode block's view; master is the surrounding pipeline's view.
interface decode_buffered_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             flush;
    logic [31:0]      instr;
    logic [XLEN-1:0]  pc_in;
    logic             valid_in;
    logic             ready_in;
    logic             ready_out;
    logic             valid_out;
    logic [XLEN-1:0]  pc_out;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [XLEN-1:0]  imm;
    logic [3:0]       ALUOp;
    logic [6:0]       OpCode;
    logic             illegal;
    logic [CNT_W-1:0] count;

    modport master (
        output flush, instr, pc_in, valid_in, ready_out,
        input  ready_in, valid_out, pc_out, rs1, rs2, rd, imm, ALUOp, OpCode, illegal, count
    );

    modport slave (
        input  flush, instr, pc_in, valid_in, ready_out,
        output ready_in, valid_out, pc_out, rs1, rs2, rd, imm, ALUOp, OpCode, illegal, count
    );
endinterface

// File: rtl/decode_buffered.sv
// RV32I decoder feeding a DEPTH-entry FIFO of decoded instructions, so fetch can
// run ahead of a stalled rename/dispatch stage. Flush discards every entry.
module decode_buffered #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    decode_buffered_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    if (XLEN != 32 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
        $error("decode_buffered: XLEN must be 32 and DEPTH a power of two >= 2");
    end

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [3:0]      alu_op;
        logic [6:0]      op_code;
        logic            illegal;
    } entry_t;

    entry_t           dec;
    entry_t           head;
    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_out;
    logic             ready_in;
    logic             push;
    logic             pop;

    always_comb begin
        dec         = '0;
        dec.pc      = bus.pc_in;
        dec.rs1     = bus.instr[19:15];
        dec.rs2     = bus.instr[24:20];
        dec.rd      = bus.instr[11:7];
        dec.alu_op  = {1'b0, bus.instr[14:12]};
        dec.op_code = bus.instr[6:0];
        case (bus.instr[6:0])
            OP_IMM: begin
                dec.imm       = {{20{bus.instr[31]}}, bus.instr[31:20]};
                // Only SRLI/SRAI use instr[30] to pick the shift flavour.
                dec.alu_op[3] = (bus.instr[14:12] == 3'b101) && bus.instr[30];
            end
            OP_LOAD, OP_JALR, OP_SYSTEM:
                dec.imm = {{20{bus.instr[31]}}, bus.instr[31:20]};
            OP_STORE: begin
                dec.imm = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
                dec.rd  = '0;
            end
            OP_BRANCH: begin
                dec.imm = {{20{bus.instr[31]}}, bus.instr[7], bus.instr[30:25],
                           bus.instr[11:8], 1'b0};
                dec.rd  = '0;
            end
            OP_LUI, OP_AUIPC:
                dec.imm = {bus.instr[31:12], 12'b0};
            OP_JAL:
                dec.imm = {{12{bus.instr[31]}}, bus.instr[19:12], bus.instr[20],
                           bus.instr[30:21], 1'b0};
            OP_REG:
                dec.alu_op[3] = bus.instr[30];
            default:
                dec.illegal = 1'b1;
        endcase
        if (bus.instr[1:0] != 2'b11) begin
            dec.illegal = 1'b1;
            dec.imm     = '0;
        end
    end

    assign valid_out = (count_q != '0);
    assign ready_in  = (count_q != FULL_CNT) && !bus.flush;
    assign push      = bus.valid_in && ready_in;
    assign pop       = valid_out && bus.ready_out && !bus.flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; valid_out gates what is visible.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= dec;
    end

    always_comb begin
        head = '0;
        if (valid_out) head = mem[rd_ptr_q];
    end

    assign bus.ready_in  = ready_in;
    assign bus.valid_out = valid_out;
    assign bus.count     = count_q;
    assign bus.pc_out    = head.pc;
    assign bus.rs1       = head.rs1;
    assign bus.rs2       = head.rs2;
    assign bus.rd        = head.rd;
    assign bus.imm       = head.imm;
    assign bus.ALUOp     = head.alu_op;
    assign bus.OpCode    = head.op_code;
    assign bus.illegal   = head.illegal;
endmodule

// File: tb/tb_decode_buffered.sv
// Bench for decode_buffered: directed scenario tasks plus a negedge scoreboard
// that predicts every decoded head entry and the occupancy/handshake signals.
module tb_decode_buffered;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [6:0]  opc;
        logic        ill;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t sb_q[$];
    int   model_count;
    exp_t act;
    bit   m_push;
    bit   m_pop;

    decode_buffered_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    decode_buffered #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t ref_decode(logic [31:0] i, logic [31:0] pc);
        exp_t       e;
        logic [6:0] op;
        bit is_i, is_s, is_b, is_u, is_j, is_r;
        op   = i[6:0];
        is_i = (op == 7'h13) || (op == 7'h03) || (op == 7'h67) || (op == 7'h73);
        is_s = (op == 7'h23);
        is_b = (op == 7'h63);
        is_u = (op == 7'h37) || (op == 7'h17);
        is_j = (op == 7'h6F);
        is_r = (op == 7'h33);
        e.pc  = pc;
        e.rs1 = i[19:15];
        e.rs2 = i[24:20];
        e.opc = op;
        e.rd  = (is_s || is_b) ? 5'd0 : i[11:7];
        e.ill = !(is_i || is_s || is_b || is_u || is_j || is_r) || (i[1:0] != 2'b11);
        e.alu = {(is_r || (op == 7'h13 && i[14:12] == 3'b101)) ? i[30] : 1'b0, i[14:12]};
        e.imm = 32'h0;
        if (is_i) e.imm = 32'($signed(i[31:20]));
        if (is_s) e.imm = 32'($signed({i[31:25], i[11:7]}));
        if (is_b) e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
        if (is_u) e.imm = {i[31:12], 12'h000};
        if (is_j) e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
        if (e.ill) e.imm = 32'h0;
        return e;
    endfunction

    // Scoreboard: predicts handshake state and the head entry every cycle.
    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
            model_count = 0;
        end else begin
            act = {bus.pc_out, bus.rs1, bus.rs2, bus.rd, bus.imm, bus.ALUOp, bus.OpCode, bus.illegal};
            checks++;
            if (bus.count !== CNT_W'(model_count)) begin
                errors++;
                $display("FAIL sb_count: got %0d expected %0d", bus.count, model_count);
            end
            checks++;
            if (bus.ready_in !== ((model_count != DEPTH) && !bus.flush)) begin
                errors++;
                $display("FAIL sb_ready_in: got %b expected %b", bus.ready_in,
                         (model_count != DEPTH) && !bus.flush);
            end
            checks++;
            if (bus.valid_out !== (model_count != 0)) begin
                errors++;
                $display("FAIL sb_valid_out: got %b expected %b", bus.valid_out, model_count != 0);
            end
            checks++;
            if (model_count != 0 && sb_q.size() != 0) begin
                if (act !== sb_q[0]) begin
                    errors++;
                    $display("FAIL sb_head: got %h expected %h", act, sb_q[0]);
                end
            end else if (act !== '0) begin
                errors++;
                $display("FAIL sb_idle_zero: got %h expected 0", act);
            end
            if (bus.flush) begin
                sb_q.delete();
                model_count = 0;
            end else begin
                m_pop  = (model_count != 0) && bus.ready_out;
                m_push = bus.valid_in && (model_count != DEPTH);
                if (m_pop) void'(sb_q.pop_front());
                if (m_push) sb_q.push_back(ref_decode(bus.instr, bus.pc_in));
                model_count = model_count + int'(m_push) - int'(m_pop);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.valid_in  = 1'b0;
        bus.ready_out = 1'b1;
        for (int k = 0; k < 20 && bus.count != '0; k++) step();
        bus.ready_out = 1'b0;
        checks++;
        if (bus.count !== '0) begin
            errors++;
            $display("FAIL drain_timeout: count %0d expected 0", bus.count);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (bus.valid_out !== 1'b0 || bus.count !== '0) begin
            errors++;
            $display("FAIL reset_state: valid_out %b count %0d expected 0 0", bus.valid_out, bus.count);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        step();
        checks++;
        if (bus.ready_in !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_in: got %b expected 1", bus.ready_in);
        end
        $display("reset: released, ready_in=%b", bus.ready_in);
    endtask

    task automatic test_single_push();
        bus.instr = 32'hFFB10093; bus.pc_in = 32'h100; bus.valid_in = 1'b1;
        step();
        bus.valid_in = 1'b0;
        checks++;
        if ({bus.valid_out, bus.rd, bus.rs1, bus.imm, bus.ALUOp, bus.OpCode, bus.illegal, bus.pc_out} !==
            {1'b1, 5'd1, 5'd2, 32'hFFFFFFFB, 4'h0, 7'h13, 1'b0, 32'h100}) begin
            errors++;
            $display("FAIL single_push: got v%b rd%0d rs1%0d imm%h alu%h op%h ill%b pc%h expected v1 rd1 rs1 2 immfffffffb alu0 op13 ill0 pc100",
                     bus.valid_out, bus.rd, bus.rs1, bus.imm, bus.ALUOp, bus.OpCode, bus.illegal, bus.pc_out);
        end
        $display("single_push: instr ffb10093 -> rd=%0d imm=%h", bus.rd, bus.imm);
        drain();
    endtask

    task automatic test_formats();
        logic [31:0] prog [3];
        prog = '{32'h00532423, 32'hFE000EE3, 32'h402081B3};
        for (int i = 0; i < 3; i++) begin
            bus.instr = prog[i]; bus.pc_in = 32'h200 + 32'(4 * i); bus.valid_in = 1'b1;
            step();
        end
        bus.valid_in = 1'b0;
        checks++;
        if ({bus.imm, bus.rs1, bus.rs2, bus.rd} !== {32'h8, 5'd6, 5'd5, 5'd0}) begin
            errors++;
            $display("FAIL fmt_store: got imm%h rs1 %0d rs2 %0d rd %0d expected imm8 rs1 6 rs2 5 rd 0",
                     bus.imm, bus.rs1, bus.rs2, bus.rd);
        end
        $display("formats: sw imm=%h", bus.imm);
        bus.ready_out = 1'b1;
        step();
        checks++;
        if ({bus.imm, bus.rd} !== {32'hFFFFFFFC, 5'd0}) begin
            errors++;
            $display("FAIL fmt_branch: got imm%h rd %0d expected fffffffc 0", bus.imm, bus.rd);
        end
        $display("formats: beq imm=%h", bus.imm);
        step();
        checks++;
        if ({bus.ALUOp, bus.imm, bus.rd} !== {4'b1000, 32'h0, 5'd3}) begin
            errors++;
            $display("FAIL fmt_sub: got alu%b imm%h rd%0d expected 1000 0 3", bus.ALUOp, bus.imm, bus.rd);
        end
        $display("formats: sub aluop=%b", bus.ALUOp);
        step();
        bus.ready_out = 1'b0;
    endtask

    task automatic test_fill_stall();
        logic [31:0] fill [5];
        fill = '{32'h00A00513, 32'h123452B7, 32'h0080006F, 32'h40F6D693, 32'h00812083};
        bus.ready_out = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.instr = fill[i]; bus.pc_in = 32'h300 + 32'(4 * i); bus.valid_in = 1'b1;
            step();
        end
        checks++;
        if (bus.count !== CNT_W'(DEPTH) || bus.ready_in !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: count %0d ready_in %b expected 4 0", bus.count, bus.ready_in);
        end
        $display("fill: count=%0d ready_in=%b", bus.count, bus.ready_in);
        bus.ready_out = 1'b1;
        step();
        checks++;
        if (bus.count !== CNT_W'(3)) begin
            errors++;
            $display("FAIL full_pop_only: count %0d expected 3", bus.count);
        end
        step();
        checks++;
        if (bus.count !== CNT_W'(3)) begin
            errors++;
            $display("FAIL fifth_accept: count %0d expected 3", bus.count);
        end
        $display("fill: fifth accepted, count=%0d", bus.count);
        drain();
    endtask

    task automatic test_streaming();
        logic [6:0]  ops [11];
        logic [31:0] r;
        ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h0B};
        bus.valid_in = 1'b1; bus.ready_out = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            r = $urandom();
            bus.instr = {r[31:7], ops[$urandom_range(0, 10)]};
            bus.pc_in = 32'h1000 + 32'(4 * i);
            step();
            checks++;
            if (bus.count !== CNT_W'(1)) begin
                errors++;
                $display("FAIL stream_count: beat %0d count %0d expected 1", i, bus.count);
            end
            $display("stream: beat %0d instr %h pc %h", i, bus.instr, bus.pc_in);
        end
        drain();
    endtask

    task automatic test_flush();
        bus.ready_out = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.instr = 32'h00100093 + 32'(i << 7); bus.pc_in = 32'h400 + 32'(4 * i); bus.valid_in = 1'b1;
            step();
        end
        bus.instr = 32'h00000513; bus.pc_in = 32'h40C; bus.flush = 1'b1;
        step();
        bus.flush = 1'b0; bus.valid_in = 1'b0;
        checks++;
        if (bus.count !== '0 || bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear: count %0d valid_out %b expected 0 0", bus.count, bus.valid_out);
        end
        step();
        checks++;
        if (bus.count !== '0) begin
            errors++;
            $display("FAIL flush_no_enq: count %0d expected 0", bus.count);
        end
        $display("flush: count=%0d valid_out=%b", bus.count, bus.valid_out);
    endtask

    task automatic test_async_reset();
        bus.ready_out = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.instr = 32'h00532423; bus.pc_in = 32'h500 + 32'(4 * i); bus.valid_in = 1'b1;
            step();
        end
        bus.valid_in = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus.valid_out, bus.count, bus.pc_out, bus.rs1, bus.rs2, bus.rd, bus.imm, bus.ALUOp,
             bus.OpCode, bus.illegal} !== '0) begin
            errors++;
            $display("FAIL async_reset: valid_out %b count %0d pc %h imm %h expected all 0",
                     bus.valid_out, bus.count, bus.pc_out, bus.imm);
        end
        $display("async_reset: count=%0d valid_out=%b", bus.count, bus.valid_out);
        @(posedge clk);
        #1 reset = 1'b0;
        bus.instr = 32'h00000000; bus.pc_in = 32'h600; bus.valid_in = 1'b1;
        step();
        bus.valid_in = 1'b0;
        checks++;
        if ({bus.valid_out, bus.illegal, bus.imm, bus.pc_out} !== {1'b1, 1'b1, 32'h0, 32'h600}) begin
            errors++;
            $display("FAIL illegal_enq: valid %b illegal %b imm %h pc %h expected 1 1 0 600",
                     bus.valid_out, bus.illegal, bus.imm, bus.pc_out);
        end
        $display("illegal: instr 00000000 illegal=%b", bus.illegal);
        drain();
    endtask

    initial begin
        checks = 0; errors = 0; model_count = 0;
        reset = 1'b1;
        bus.flush = 1'b0; bus.instr = '0; bus.pc_in = '0; bus.valid_in = 1'b0; bus.ready_out = 1'b0;
        test_reset();
        test_single_push();
        test_formats();
        test_fill_stall();
        test_streaming();
        test_flush();
        test_async_reset();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
